evt2_encoder: RTL and testbench
===============================

EVT2_ENCODER -- requirements
Module: evt2_encoder

Interface
REQ-001 SHALL have parameter SENSOR_W, default 320, meaning exclusive upper bound on accepted x.
REQ-002 SHALL have parameter SENSOR_H, default 320, meaning exclusive upper bound on accepted y.
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  event offered.
REQ-006 SHALL have port in_ready  output  1  event accepted on the edge where in_valid && in_ready.
REQ-007 SHALL have port in_x  input  11  event column.
REQ-008 SHALL have port in_y  input  11  event row.
REQ-009 SHALL have port in_pol  input  1  polarity; 1 = ON, 0 = OFF.
REQ-010 SHALL have port in_ts  input  34  event timestamp in µs.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid EVT 2.0 word.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the word on the edge where out_valid && out_ready.
REQ-013 SHALL have port out_data  output  32  EVT 2.0 word.
REQ-014 SHALL have port drop_count  output  16  count of out-of-range events dropped; saturating.
REQ-015 SHALL have port th_count  output  16  count of TIME_HIGH words emitted; wraps.

Function
REQ-016 SHALL encode a CD word as: [31:28] = 4'h1 if pol else 4'h0; [27:22] = ts[5:0]; [21:11] = x; [10:0] = y.
REQ-017 SHALL encode a TIME_HIGH word as: [31:28] = 4'h8; [27:0] = ts[33:6].
REQ-018 SHALL hold a register last_th[27:0] and a flag th_valid; th_needed = !th_valid || in_ts[33:6] != last_th; any difference counts, including wrap or backwards time.
REQ-019 SHALL implement the FSM states IDLE, SEND_TH and SEND_CD; out_valid = (state != IDLE).
REQ-020 SHALL drive in_ready = (state == IDLE) || (state == SEND_CD && out_ready), combinationally.
REQ-021 On acceptance of an in-range event, SHALL latch x, y, pol and ts, and load out_data on the same edge:
  - next state SEND_TH with the TIME_HIGH word if th_needed;
  - otherwise next state SEND_CD with the CD word.
REQ-022 SHALL give one cycle of latency from acceptance to out_valid.
REQ-023 In SEND_TH, on out_ready: last_th <= latched ts[33:6]; th_valid <= 1; th_count += 1; out_data <= the CD word; next state SEND_CD.
REQ-024 In SEND_CD, on out_ready:
  - accept a new event if in_valid, per REQ-021;
  - else go to IDLE.
REQ-025 For a back-to-back event in SEND_CD, SHALL evaluate th_needed against last_th as already updated.
REQ-026 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-027 An accepted event with x >= SENSOR_W or y >= SENSOR_H:
  - SHALL emit nothing and SHALL leave last_th unchanged;
  - SHALL increment drop_count, saturating at 16'hFFFF;
  - next state IDLE.
REQ-028 SHALL have no internal event queue; backpressure reaches the source only through in_ready.

Reset
REQ-029 While rst is high, SHALL hold: state = IDLE, out_valid = 0, out_data = 0, th_valid = 0, last_th = 0, drop_count = 0, th_count = 0.
REQ-030 Reset asserted mid-transfer SHALL abandon the pending word; the first event after reset SHALL always be preceded by TIME_HIGH.

Verification
REQ-031 Event x=5, y=7, pol=1, ts=69 after reset, out_ready=1 -> out_data 0x80000001, then 0x11402807; th_count = 1.
REQ-032 Follow-up event x=10, y=3, pol=0, ts=74 -> single word 0x02805003; no TIME_HIGH.
REQ-033 Event ts=128 after ts=74 -> TIME_HIGH 0x80000002 precedes the CD word.
REQ-034 out_ready held low 5 cycles while in SEND_TH:
  - out_data stays 0x80000001;
  - in_ready = 0;
  - nothing is lost after release.
REQ-035 Event x=320, y=0 -> no output; drop_count = 1; in_ready returns high the next cycle.
REQ-036 rst pulsed while in SEND_CD -> out_valid = 0 immediately; the next event emits TIME_HIGH first.

Source files
------------

// File: rtl/evt2_encoder.sv
// ---------------------------------------------------------------------------
// evt2_encoder
//   Turns (x, y, pol, ts) sensor events into a stream of EVT 2.0 32-bit words.
//   A CD word carries the low 6 timestamp bits. A TIME_HIGH word carrying
//   ts[33:6] goes out first whenever the upper timestamp differs from the
//   last one sent, or when none has been sent since reset.
//   Events outside the sensor array are dropped and counted.
//
// Ports
//   clk, rst               : clock, async active-high reset
//   in_valid/in_ready      : event handshake; in_x, in_y, in_pol, in_ts payload
//   out_valid/out_ready    : word handshake; out_data = EVT 2.0 word
//   drop_count             : out-of-range events dropped (saturating)
//   th_count               : TIME_HIGH words emitted (wrapping)
// ---------------------------------------------------------------------------
module evt2_encoder #(
    parameter int unsigned SENSOR_W = 320,
    parameter int unsigned SENSOR_H = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_x,
    input  logic [10:0] in_y,
    input  logic        in_pol,
    input  logic [33:0] in_ts,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] drop_count,
    output logic [15:0] th_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TH   = 2'd1;
    localparam logic [1:0] ST_CD   = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic [10:0] x_q,       x_d;
    logic [10:0] y_q,       y_d;
    logic        pol_q,     pol_d;
    logic [33:0] ts_q,      ts_d;
    logic [27:0] last_th_q, last_th_d;
    logic        th_vld_q,  th_vld_d;
    logic [31:0] data_q,    data_d;
    logic [15:0] drop_q,    drop_d;
    logic [15:0] thc_q,     thc_d;

    logic take;
    logic in_range;
    logic th_needed;

    function automatic logic [31:0] cd_word(input logic        pol,
                                            input logic [5:0]  ts_lo,
                                            input logic [10:0] x,
                                            input logic [10:0] y);
        return {(pol ? 4'h1 : 4'h0), ts_lo, x, y};
    endfunction

    // A new event may enter when nothing is pending, or when the last word
    // of the current event (the CD word) leaves on this same edge.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_CD) && out_ready);
    assign take      = in_valid && in_ready;
    assign in_range  = ({21'd0, in_x} < 32'(SENSOR_W)) && ({21'd0, in_y} < 32'(SENSOR_H));
    // last_th_q already reflects a TIME_HIGH that left earlier, so a
    // back-to-back event compares against the freshly updated value.
    assign th_needed = !th_vld_q || (in_ts[33:6] != last_th_q);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        pol_d     = pol_q;
        ts_d      = ts_q;
        last_th_d = last_th_q;
        th_vld_d  = th_vld_q;
        data_d    = data_q;
        drop_d    = drop_q;
        thc_d     = thc_q;

        case (state_q)
            ST_IDLE: ;
            ST_TH: begin
                if (out_ready) begin
                    last_th_d = ts_q[33:6];
                    th_vld_d  = 1'b1;
                    thc_d     = thc_q + 16'd1;
                    data_d    = cd_word(pol_q, ts_q[5:0], x_q, y_q);
                    state_d   = ST_CD;
                end
            end
            ST_CD: begin
                if (out_ready && !in_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance overrides the SEND_CD -> IDLE path above.
        if (take) begin
            if (in_range) begin
                x_d   = in_x;
                y_d   = in_y;
                pol_d = in_pol;
                ts_d  = in_ts;
                if (th_needed) begin
                    data_d  = {4'h8, in_ts[33:6]};
                    state_d = ST_TH;
                end else begin
                    data_d  = cd_word(in_pol, in_ts[5:0], in_x, in_y);
                    state_d = ST_CD;
                end
            end else begin
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            pol_q     <= 1'b0;
            ts_q      <= '0;
            last_th_q <= '0;
            th_vld_q  <= 1'b0;
            data_q    <= '0;
            drop_q    <= '0;
            thc_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pol_q     <= pol_d;
            ts_q      <= ts_d;
            last_th_q <= last_th_d;
            th_vld_q  <= th_vld_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
            thc_q     <= thc_d;
        end
    end

    assign out_valid  = (state_q != ST_IDLE);
    assign out_data   = data_q;
    assign drop_count = drop_q;
    assign th_count   = thc_q;

endmodule

// File: tb/tb_evt2_encoder.sv
// ---------------------------------------------------------------------------
// tb_evt2_encoder
//   Bench for evt2_encoder. The reference model keeps a queue of the words
//   each accepted event must produce, plus the last TIME_HIGH value emitted.
//   Outputs are checked every falling edge. Directed sequences pin the model
//   with literal words. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_evt2_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_x = '0;
    logic [10:0] in_y = '0;
    logic        in_pol = 1'b0;
    logic [33:0] in_ts = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] drop_count;
    logic [15:0] th_count;

    int checks = 0;
    int failures = 0;

    evt2_encoder #(.SENSOR_W(320), .SENSOR_H(320)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_pol(in_pol), .in_ts(in_ts),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_count(drop_count), .th_count(th_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] pend[$];     // words still owed for accepted events
    logic [31:0] seen[$];     // words the DUT actually handed downstream
    logic [27:0] m_last;
    bit          m_thv;
    int          m_drop;
    int          m_thc;

    // Check on the falling edge, then advance the model to the state it
    // must be in after the next rising edge. Inputs are stable in between.
    always @(negedge clk) begin
        bit          exp_rdy;
        logic [31:0] w;
        if (rst) begin
            pend.delete();
            m_last = '0;
            m_thv  = 0;
            m_drop = 0;
            m_thc  = 0;
            chk("rst_out_data", out_data, 32'd0);
        end
        exp_rdy = (pend.size() == 0) || (pend.size() == 1 && out_ready);
        chk("out_valid", out_valid, pend.size() != 0);
        if (pend.size() != 0) chk("out_data", out_data, pend[0]);
        chk("in_ready", in_ready, exp_rdy);
        chk("drop_count", drop_count, 16'(m_drop));
        chk("th_count", th_count, 16'(m_thc));
        if (out_valid && out_ready) seen.push_back(out_data);
        if (!rst) begin
            if (pend.size() != 0 && out_ready) begin
                w = pend.pop_front();
                if (w[31:28] == 4'h8) begin
                    m_last = w[27:0];
                    m_thv  = 1;
                    m_thc  = (m_thc + 1) % 65536;
                end
            end
            if (in_valid && exp_rdy) begin
                if (in_x < 320 && in_y < 320) begin
                    if (!m_thv || in_ts[33:6] != m_last) pend.push_back({4'h8, in_ts[33:6]});
                    pend.push_back({(in_pol ? 4'h1 : 4'h0), in_ts[5:0], in_x, in_y});
                end else if (m_drop < 65535) begin
                    m_drop = m_drop + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input bit pol, input logic [33:0] ts);
        bit acc = 0;
        in_valid = 1'b1;
        in_x = 11'(x);
        in_y = 11'(y);
        in_pol = pol;
        in_ts = ts;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        step();
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic expect_seen(input int n, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [31:0] w4);
        logic [31:0] ws[5];
        ws = '{w0, w1, w2, w3, w4};
        chk("seen_len", seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++) chk($sformatf("seen[%0d]", i), seen[i], ws[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] tsb;
        // reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_thc", th_count, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // first event, same-window follow-up, then a new window
        seen.delete();
        send(5, 7, 1, 34'd69);
        send(10, 3, 0, 34'd74);
        send(1, 2, 1, 34'd128);
        repeat (5) step();
        expect_seen(5, 32'h80000001, 32'h11402807, 32'h02805003, 32'h80000002, 32'h10000802);
        chk("thc_after_3", th_count, 2);

        // backpressure while the TIME_HIGH word is pending
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        seen.delete();
        send(5, 7, 1, 34'd69);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", out_data, 32'h80000001);
            chk("stall_in_ready", in_ready, 0);
        end
        step();
        out_ready = 1'b1;
        repeat (4) step();
        expect_seen(2, 32'h80000001, 32'h11402807, 0, 0, 0);

        // out-of-range event is dropped
        seen.delete();
        send(320, 0, 0, 34'd5);
        @(negedge clk);
        chk("drop_in_ready", in_ready, 1);
        chk("drop_out_valid", out_valid, 0);
        chk("drop_count1", drop_count, 1);
        step();
        chk("drop_no_word", seen.size(), 0);

        // reset while the CD word is pending
        out_ready = 1'b0;
        send(5, 7, 1, 34'd69);
        @(negedge clk);
        chk("cd_pending_valid", out_valid, 1);
        chk("cd_pending_data", out_data, 32'h11402807);
        step();
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        seen.delete();
        send(5, 7, 1, 34'd69);
        repeat (4) step();
        expect_seen(2, 32'h80000001, 32'h11402807, 0, 0, 0);

        // randomized phase
        tsb = 34'd1000;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 19))
                0:       tsb = {2'($urandom), 32'($urandom)};
                1:       tsb = tsb - 34'($urandom_range(0, 200));
                default: tsb = tsb + 34'($urandom_range(0, 40));
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_x      = 11'($urandom_range(0, 330));
            in_y      = 11'($urandom_range(0, 330));
            in_pol    = 1'($urandom);
            in_ts     = tsb;
            rst       = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
